// File: rtl/audio_out_arbiter.sv
// Four-requester arbiter feeding stereo sample pairs to an audio controller in bounded bursts.
// Define AUDIO_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest); round-robin otherwise.
module audio_out_arbiter #(
  parameter int AUDIO_DATA_WIDTH = 10,
  parameter int BURST_LEN        = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [3:0]                    req,
  input  logic [4*AUDIO_DATA_WIDTH-1:0] req_left,
  input  logic [4*AUDIO_DATA_WIDTH-1:0] req_right,
  output logic [3:0]                    ack,
  output logic [3:0]                    grant,
  output logic                          busy,
  input  logic                          audio_out_allowed,
  output logic [AUDIO_DATA_WIDTH-1:0]   left_channel_audio_out,
  output logic [AUDIO_DATA_WIDTH-1:0]   right_channel_audio_out,
  output logic                          write_audio_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [3:0]                  r_grant;
  logic [3:0]                  w_grant;
  logic [1:0]                  r_owner;
  logic [1:0]                  w_owner;
  logic [7:0]                  r_burst_cnt;
  logic [7:0]                  w_burst_cnt;
  logic [7:0]                  w_cnt_inc;
  logic [3:0]                  r_ack;
  logic [3:0]                  w_ack;
  logic                        r_write;
  logic                        w_write;
  logic                        r_busy;
  logic                        w_busy;
  logic [AUDIO_DATA_WIDTH-1:0] r_left;
  logic [AUDIO_DATA_WIDTH-1:0] w_left;
  logic [AUDIO_DATA_WIDTH-1:0] r_right;
  logic [AUDIO_DATA_WIDTH-1:0] w_right;
  logic [AUDIO_DATA_WIDTH-1:0] w_owner_left;
  logic [AUDIO_DATA_WIDTH-1:0] w_owner_right;
  logic                        w_owner_req;
  logic [1:0]                  w_search_start;
  logic [1:0]                  w_winner;
  logic                        w_release;

  // First requesting index at or after start, wrapping modulo 4
  function automatic logic [1:0] pick_winner(input logic [3:0] req_v, input logic [1:0] start);
    logic [1:0] idx;
    pick_winner = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req_v[idx]) begin
        pick_winner = idx;
      end
    end
  endfunction

`ifdef AUDIO_ARB_FIXED_PRIO_EN
  assign w_search_start = 2'd0;
`else
  logic [1:0] r_last_owner;

  // Round-robin pointer; starting at 3 makes the first search begin at index 0
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_last_owner <= 2'd3;
    end else if (w_release) begin
      r_last_owner <= r_owner;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

  assign w_search_start = r_last_owner + 2'd1;
`endif

  assign w_winner  = pick_winner(req, w_search_start);
  assign w_cnt_inc = (r_burst_cnt == 8'hFF) ? r_burst_cnt : r_burst_cnt + 8'd1;

  // Owner's request and sample pair
  always_comb begin
    w_owner_req   = req[0];
    w_owner_left  = req_left[AUDIO_DATA_WIDTH-1:0];
    w_owner_right = req_right[AUDIO_DATA_WIDTH-1:0];
    for (int i = 1; i < 4; i++) begin
      if (r_owner == 2'(i)) begin
        w_owner_req   = req[i];
        w_owner_left  = req_left[i*AUDIO_DATA_WIDTH +: AUDIO_DATA_WIDTH];
        w_owner_right = req_right[i*AUDIO_DATA_WIDTH +: AUDIO_DATA_WIDTH];
      end else begin
        w_owner_req   = w_owner_req;
        w_owner_left  = w_owner_left;
        w_owner_right = w_owner_right;
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_next_state = r_state;
    w_grant      = r_grant;
    w_owner      = r_owner;
    w_burst_cnt  = r_burst_cnt;
    w_ack        = 4'd0;
    w_write      = 1'b0;
    w_left       = r_left;
    w_right      = r_right;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner      = w_winner;
          w_grant      = 4'b0001 << w_winner;
          w_burst_cnt  = 8'd0;
          w_next_state = S_OWN;
        end else begin
          w_grant      = 4'd0;
          w_next_state = S_IDLE;
        end
      end
      S_OWN: begin
        if (!w_owner_req) begin
          w_grant      = 4'd0;
          w_next_state = S_IDLE;
        end else if (audio_out_allowed) begin
          w_left       = w_owner_left;
          w_right      = w_owner_right;
          w_write      = 1'b1;
          w_ack        = r_grant;
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_OWN;
        end
      end
      S_WRITE: begin
        w_burst_cnt = w_cnt_inc;
        // The owner dropping req while being acked releases here, so no extra write
        if ((w_cnt_inc >= BURST_LEN_C) || !w_owner_req) begin
          w_release    = 1'b1;
          w_grant      = 4'd0;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_OWN;
        end
      end
      default: begin
        w_grant      = 4'd0;
        w_next_state = S_IDLE;
      end
    endcase
    w_busy = (w_next_state != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= 4'd0;
      r_owner     <= 2'd0;
      r_burst_cnt <= 8'd0;
      r_ack       <= 4'd0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_grant     <= w_grant;
      r_owner     <= w_owner;
      r_burst_cnt <= w_burst_cnt;
      r_ack       <= w_ack;
      r_write     <= w_write;
      r_busy      <= w_busy;
      r_left      <= w_left;
      r_right     <= w_right;
    end
  end

  assign grant                   = r_grant;
  assign ack                     = r_ack;
  assign busy                    = r_busy;
  assign write_audio_out         = r_write;
  assign left_channel_audio_out  = r_left;
  assign right_channel_audio_out = r_right;

endmodule

// File: tb/tb_audio_out_arbiter.sv
// Scoreboard bench for audio_out_arbiter: a BURST_LEN=8 instance plus a BURST_LEN=2 instance
// sharing stimulus; expected writes are queued when stimulus is driven and popped on write pulses.
module tb_audio_out_arbiter;
  localparam int W = 10;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic           reset;
  logic [3:0]     req;
  logic [4*W-1:0] req_left;
  logic [4*W-1:0] req_right;
  logic           audio_out_allowed;
  logic [3:0]     ack, grant, ack2, grant2;
  logic           busy, write_audio_out, busy2, write2;
  logic [W-1:0]   left_out, right_out, left2, right2;

  audio_out_arbiter #(.AUDIO_DATA_WIDTH(W), .BURST_LEN(8)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_left(req_left), .req_right(req_right),
    .ack(ack), .grant(grant), .busy(busy), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
    .write_audio_out(write_audio_out));

  audio_out_arbiter #(.AUDIO_DATA_WIDTH(W), .BURST_LEN(2)) dut2 (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_left(req_left), .req_right(req_right),
    .ack(ack2), .grant(grant2), .busy(busy2), .audio_out_allowed(audio_out_allowed),
    .left_channel_audio_out(left2), .right_channel_audio_out(right2),
    .write_audio_out(write2));

  typedef struct packed {
    logic [1:0]   owner;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb2_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_sample(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
    req_left[i*W +: W]  = l;
    req_right[i*W +: W] = r;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 4'd0;
    audio_out_allowed = 1'b0;
    req_left = '0;
    req_right = '0;
    sb_q.delete();
    sb2_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Cycle invariants: no back-to-back writes, ack equals grant on writes and is zero otherwise
  logic prev_write = 1'b0;
  logic prev_write2 = 1'b0;
  always @(negedge CLOCK_50) begin
    n_tests++;
    if ((write_audio_out && prev_write) || (write2 && prev_write2)) begin
      n_fail++;
      $display("FAIL back_to_back_write: write=%b/%b prev=%b/%b required no consecutive writes",
               write_audio_out, write2, prev_write, prev_write2);
    end
    n_tests++;
    if ((write_audio_out ? (ack !== grant) : (ack !== 4'd0)) ||
        (write2 ? (ack2 !== grant2) : (ack2 !== 4'd0))) begin
      n_fail++;
      $display("FAIL ack_vs_grant: ack=%b grant=%b write=%b ack2=%b grant2=%b write2=%b",
               ack, grant, write_audio_out, ack2, grant2, write2);
    end
    prev_write  = write_audio_out;
    prev_write2 = write2;
  end

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    audio_out_allowed = 1'b1;
    req_left = '1;
    req_right = '1;
    tick();
    n_tests++;
    if ({grant, ack, busy, write_audio_out, left_out, right_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b ack=%b busy=%b wr=%b l=%h r=%h required all 0",
               grant, ack, busy, write_audio_out, left_out, right_out);
    end
    n_tests++;
    if ({grant2, ack2, busy2, write2, left2, right2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: grant=%b ack=%b busy=%b wr=%b required all 0",
               grant2, ack2, busy2, write2);
    end
  endtask

  task automatic test_single_burst();
    exp_t e;
    int writes;
    int cyc;
    int last_cyc;
    logic [W-1:0] l;
    do_reset();
    audio_out_allowed = 1'b1;
    set_sample(0, 10'h001, 10'h3FE);
    sb_q.push_back({2'd0, 10'h001, 10'h3FE});
    req = 4'b0001;
    tick();
    n_tests++;
    if (grant !== 4'b0001 || write_audio_out !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_grant_latency: grant=%b wr=%b required 0001/0", grant, write_audio_out);
    end
    writes = 0;
    cyc = 0;
    last_cyc = 0;
    for (int c = 0; c < 60 && writes < 8; c++) begin
      tick();
      cyc++;
      if (write_audio_out) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL burst_unexpected_write: write at cycle %0d required none", cyc);
        end else begin
          e = sb_q.pop_front();
          if ({ack, left_out, right_out} !== {onehot(e.owner), e.l, e.r}) begin
            n_fail++;
            $display("FAIL burst_data: ack=%b l=%h r=%h required %b %h %h",
                     ack, left_out, right_out, onehot(e.owner), e.l, e.r);
          end
        end
        n_tests++;
        if ((writes == 0 && cyc != 1) || (writes > 0 && cyc - last_cyc != 2)) begin
          n_fail++;
          $display("FAIL burst_spacing: write %0d at cycle %0d previous %0d", writes, cyc, last_cyc);
        end
        last_cyc = cyc;
        writes++;
        if (writes < 8) begin
          l = 10'h001 + 10'(writes);
          set_sample(0, l, ~l);
          sb_q.push_back({2'd0, l, ~l});
        end
      end
    end
    n_tests++;
    if (writes != 8) begin
      n_fail++;
      $display("FAIL burst_write_count: got %0d required 8", writes);
    end
    tick();
    n_tests++;
    if (grant !== 4'd0 || busy !== 1'b0 || write_audio_out !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_release: grant=%b busy=%b wr=%b required 0/0/0", grant, busy, write_audio_out);
    end
    req = 4'd0;
    tick();
    n_tests++;
    if (grant !== 4'd0) begin
      n_fail++;
      $display("FAIL burst_idle: grant=%b required 0000", grant);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [1:0] o;
    do_reset();
    audio_out_allowed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_sample(i, 10'h100 + 10'(i), 10'h200 + 10'(i));
    end
    for (int k = 0; k < 10; k++) begin
`ifdef AUDIO_ARB_FIXED_PRIO_EN
      o = 2'd0;
`else
      o = 2'(k / 2);
`endif
      sb2_q.push_back({o, 10'h100 + 10'(o), 10'h200 + 10'(o)});
    end
    req = 4'b1111;
    for (int c = 0; c < 200 && sb2_q.size() > 0; c++) begin
      tick();
      if (write2) begin
        e = sb2_q.pop_front();
        n_tests++;
        if ({ack2, left2, right2} !== {onehot(e.owner), e.l, e.r}) begin
          n_fail++;
          $display("FAIL rr_order: ack=%b l=%h r=%h required %b %h %h",
                   ack2, left2, right2, onehot(e.owner), e.l, e.r);
        end
      end
    end
    n_tests++;
    if (sb2_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d writes outstanding required 0", sb2_q.size());
    end
    req = 4'd0;
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    set_sample(0, 10'h0F0, 10'h30F);
    sb_q.push_back({2'd0, 10'h0F0, 10'h30F});
    req = 4'b0001;
    tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_grant: grant=%b required 0001", grant);
    end
    repeat (10) begin
      tick();
      n_tests++;
      if (grant !== 4'b0001 || write_audio_out !== 1'b0 || ack !== 4'd0) begin
        n_fail++;
        $display("FAIL stall_hold: grant=%b wr=%b ack=%b required 0001/0/0000", grant, write_audio_out, ack);
      end
    end
    audio_out_allowed = 1'b1;
    tick();
    n_tests++;
    if (write_audio_out !== 1'b1 || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL stall_resume: wr=%b required 1", write_audio_out);
    end else begin
      e = sb_q.pop_front();
      if ({ack, left_out, right_out} !== {onehot(e.owner), e.l, e.r}) begin
        n_fail++;
        $display("FAIL stall_data: ack=%b l=%h r=%h required %b %h %h",
                 ack, left_out, right_out, onehot(e.owner), e.l, e.r);
      end
    end
    req = 4'd0;
    tick();
    n_tests++;
    if (grant !== 4'd0 || write_audio_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drop_release: grant=%b wr=%b required 0000/0", grant, write_audio_out);
    end
  endtask

  task automatic test_data_hold();
    exp_t e;
    do_reset();
    audio_out_allowed = 1'b1;
    set_sample(2, 10'h155, 10'h2AA);
    sb_q.push_back({2'd2, 10'h155, 10'h2AA});
    req = 4'b0100;
    tick();
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL hold_grant: grant=%b required 0100", grant);
    end
    tick();
    n_tests++;
    if (write_audio_out !== 1'b1 || sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL hold_write: wr=%b required 1", write_audio_out);
    end else begin
      e = sb_q.pop_front();
      if ({ack, left_out, right_out} !== {onehot(e.owner), e.l, e.r}) begin
        n_fail++;
        $display("FAIL hold_data: ack=%b l=%h r=%h required %b %h %h",
                 ack, left_out, right_out, onehot(e.owner), e.l, e.r);
      end
    end
    req = 4'd0;
    set_sample(2, 10'h0AB, 10'h0CD);
    repeat (4) begin
      tick();
      n_tests++;
      if (write_audio_out !== 1'b0 || grant !== 4'd0 || left_out !== 10'h155 || right_out !== 10'h2AA) begin
        n_fail++;
        $display("FAIL hold_value: wr=%b grant=%b l=%h r=%h required 0/0000/155/2aa",
                 write_audio_out, grant, left_out, right_out);
      end
    end
  endtask

  task automatic test_drop_in_own();
    do_reset();
    req = 4'b0010;
    tick();
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_grant: grant=%b required 0010", grant);
    end
    req = 4'd0;
    tick();
    n_tests++;
    if (grant !== 4'd0 || busy !== 1'b0 || write_audio_out !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_release: grant=%b busy=%b wr=%b required 0000/0/0", grant, busy, write_audio_out);
    end
    audio_out_allowed = 1'b1;
    repeat (3) begin
      tick();
      n_tests++;
      if (write_audio_out !== 1'b0 || grant !== 4'd0) begin
        n_fail++;
        $display("FAIL drop_no_write: wr=%b grant=%b required 0/0000", write_audio_out, grant);
      end
    end
  endtask

  task automatic test_no_preempt();
    int writes;
    logic [3:0] want;
    do_reset();
    audio_out_allowed = 1'b1;
    req = 4'b0001;
    tick();
    tick();
    writes = write_audio_out ? 1 : 0;
    req = 4'b1001;
    for (int c = 0; c < 40 && grant == 4'b0001; c++) begin
      tick();
      if (write_audio_out) writes++;
    end
    n_tests++;
    if (grant !== 4'd0 || writes != 8) begin
      n_fail++;
      $display("FAIL preempt_burst: grant=%b writes=%0d required 0000 after 8", grant, writes);
    end
    tick();
`ifdef AUDIO_ARB_FIXED_PRIO_EN
    want = 4'b0001;
`else
    want = 4'b1000;
`endif
    n_tests++;
    if (grant !== want) begin
      n_fail++;
      $display("FAIL preempt_next_owner: grant=%b required %b", grant, want);
    end
    req = 4'd0;
  endtask

  task automatic test_reset_in_write();
    do_reset();
    audio_out_allowed = 1'b1;
    set_sample(0, 10'h3FF, 10'h3FF);
    req = 4'b0001;
    tick();
    tick();
    n_tests++;
    if (write_audio_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_write: wr=%b required 1", write_audio_out);
    end
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({grant, ack, busy, write_audio_out, left_out, right_out} !== '0) begin
      n_fail++;
      $display("FAIL rst_in_write: grant=%b ack=%b busy=%b wr=%b l=%h r=%h required all 0",
               grant, ack, busy, write_audio_out, left_out, right_out);
    end
    tick();
    reset = 1'b0;
    req = 4'b1111;
    tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_restart_index0: grant=%b required 0001", grant);
    end
    req = 4'd0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_stall();
    test_data_hold();
    test_drop_in_own();
    test_no_preempt();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_out_arbiter.md
AUDIO_OUT_ARBITER -- requirements
Module: audio_out_arbiter

Interface
REQ-001 Parameter AUDIO_DATA_WIDTH, default 10: sample width per channel, in bits.
REQ-002 Parameter BURST_LEN, default 8: maximum samples written per grant; legal range 1..255.
REQ-003 Port CLOCK_50  input  1: single clock; all logic samples on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port req  input  4: req[i] high means requester i has a valid sample pair presented.
REQ-006 Port req_left  input  4*AUDIO_DATA_WIDTH: left sample of requester i at bits [i*W +: W].
REQ-007 Port req_right  input  4*AUDIO_DATA_WIDTH: right sample of requester i at bits [i*W +: W].
REQ-008 Port ack  output  4: one-cycle pulse on ack[i] when requester i's sample pair is written.
REQ-009 Port grant  output  4: one-hot current owner; all zero when no owner.
REQ-010 Port busy  output  1: high whenever the state is not IDLE.
REQ-011 Port audio_out_allowed  input  1: space indication from the audio controller.
REQ-012 Port left_channel_audio_out  output  AUDIO_DATA_WIDTH: registered left sample to the audio controller.
REQ-013 Port right_channel_audio_out  output  AUDIO_DATA_WIDTH: registered right sample to the audio controller.
REQ-014 Port write_audio_out  output  1: registered one-cycle write strobe to the audio controller.

Function
REQ-015 The FSM SHALL have three states: IDLE, OWN, WRITE.
REQ-016 In IDLE with any req bit high, the block SHALL select a winner, load grant one-hot, clear the burst counter and enter OWN on the next edge.
REQ-017 Winner selection SHALL be round-robin: the search starts at index (last_owner+1) mod 4, and last_owner is 3 after reset.
REQ-018 In OWN:
- req[owner] low: the block SHALL clear grant and go to IDLE without a write.
- req[owner] high and audio_out_allowed high: the block SHALL capture the owner's req_left/req_right into the output registers, assert write_audio_out and ack[owner] for exactly one cycle, and enter WRITE.
- audio_out_allowed low: the block SHALL stall in OWN with grant held.
REQ-019 In WRITE:
- write_audio_out and ack SHALL deassert.
- The burst counter SHALL increment.
- If the count reaches BURST_LEN or req[owner] is low, the block SHALL record last_owner, clear grant and go to IDLE; otherwise it SHALL return to OWN.
REQ-020 Latency SHALL be as follows: req high at edge t in IDLE gives grant at t+1, and with allowed high at t+1, write_audio_out and ack at t+2.
REQ-021 Maximum throughput SHALL be one sample pair per 2 cycles; write_audio_out SHALL never be high on two consecutive cycles.
REQ-022 The output sample registers SHALL hold their last written value between writes.
REQ-023 ack SHALL be one-hot or zero, and SHALL equal grant whenever write_audio_out is high.
REQ-024 The burst counter SHALL be 8 bits and SHALL NOT wrap; release occurs at BURST_LEN.
REQ-025 A requester dropping req in the same cycle it is acked SHALL cause release in WRITE, with no extra write.
REQ-026 Requests arriving while the FSM is in OWN or WRITE SHALL wait; they SHALL NOT preempt the owner.

Reset
REQ-027 While reset is high:
- state = IDLE
- grant = 0, ack = 0, busy = 0, write_audio_out = 0
- both sample outputs = 0
- burst counter = 0, last_owner = 3
REQ-028 Reset asserted mid-burst SHALL abort immediately with no further write; after release, arbitration restarts from index 0.

Configuration
REQ-029 Macro AUDIO_ARB_FIXED_PRIO_EN SHALL select the arbitration policy:
- Defined: winner selection is fixed priority (index 0 highest) and last_owner is unused.
- Undefined: round-robin per REQ-017.

Verification
REQ-030 After reset, req=4'b0001 with allowed held high and BURST_LEN=8 -> grant=0001 at t+1; 8 write pulses spaced 2 cycles apart, each with ack[0]; then grant=0.
REQ-031 req=4'b1111 constant, BURST_LEN=2 -> owners in order 0,1,2,3,0 (round-robin); with the macro defined, owner is 0 every time.
REQ-032 Owner granted, allowed=0 for 10 cycles -> grant held, no write, no ack; allowed=1 -> write on the next cycle.
REQ-033 req[2] high with req_left=10'h155 and req_right=10'h2AA -> write_audio_out pulse with outputs 10'h155/10'h2AA; the outputs hold those values afterwards.
REQ-034 req[1] dropped in OWN -> return to IDLE and grant=0 with no write; reset asserted in WRITE -> all outputs 0 in the same cycle.
